// File: rtl/ep_arb_pkg.sv
// Shared types and constants for the endpoint arbiter: FSM encoding and the
// values driven onto the core TRN tx port when no channel holds the grant.
package ep_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_BUSY  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam logic [7:0]  TREM_IDLE = 8'hFF;
  localparam logic [63:0] TD_IDLE   = 64'h0;

endpackage

// File: rtl/ep_arb_rr_pick.sv
// Combinational round-robin priority encoder: first requester strictly after
// ptr, wrapping, so the last grantee has lowest priority.
module rr_pick #(
  parameter int NCH = 2,
  parameter int IW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic           valid,
  output logic [IW-1:0]  idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NCH; i++) begin
      if (!valid && req[(int'(ptr) + i) % NCH]) begin
        valid = 1'b1;
        idx   = IW'((int'(ptr) + i) % NCH);
      end
    end
  end

endmodule

// File: rtl/ep_arb.sv
// Endpoint-level arbiter: grants one channel at a time the shared TRN tx
// interface in round-robin order and muxes the grantee onto the core port.
module ep_arb
  import ep_arb_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int GNT_TMO = 16,
  parameter int IW      = $clog2(NCH),
  parameter int CW      = $clog2(GNT_TMO + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    chn_reqep,
  input  logic [NCH-1:0]    chn_drvn,
  output logic [NCH-1:0]    chn_trn,
  input  logic [64*NCH-1:0] ch_trn_td,
  input  logic [8*NCH-1:0]  ch_trn_trem_n,
  input  logic [NCH-1:0]    ch_trn_tsof_n,
  input  logic [NCH-1:0]    ch_trn_teof_n,
  input  logic [NCH-1:0]    ch_trn_tsrc_rdy_n,
  output logic [63:0]       trn_td,
  output logic [7:0]        trn_trem_n,
  output logic              trn_tsof_n,
  output logic              trn_teof_n,
  output logic              trn_tsrc_rdy_n,
  output logic [IW-1:0]     gnt_idx,
  output logic              arb_busy,
  output logic              drv_err
);

  state_t         state, state_nxt;
  logic [NCH-1:0] trn_nxt;
  logic [IW-1:0]  ptr, ptr_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           pick_vld;
  logic [IW-1:0]  pick_idx;
  logic [NCH-1:0] ill, ill_q;

  rr_pick #(.NCH(NCH), .IW(IW)) u_pick (
    .req   (chn_reqep),
    .ptr   (ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  // ptr only moves on grant, so it doubles as the current/last grantee
  assign gnt_idx  = ptr;
  assign arb_busy = (state == S_GRANT) || (state == S_BUSY);
  assign ill      = chn_drvn & ~chn_trn;

  always_comb begin
    state_nxt = state;
    trn_nxt   = chn_trn;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (pick_vld) begin
          trn_nxt   = NCH'(1) << pick_idx;
          ptr_nxt   = pick_idx;
          cnt_nxt   = '0;
          state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (chn_drvn[ptr]) begin
          state_nxt = S_BUSY;
        end else if (!chn_reqep[ptr] || cnt == CW'(GNT_TMO - 1)) begin
          trn_nxt   = '0;
          state_nxt = S_GAP;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_BUSY: begin
        if (!chn_drvn[ptr]) begin
          trn_nxt   = '0;
          state_nxt = S_GAP;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      chn_trn <= '0;
      ptr     <= IW'(NCH - 1);
      cnt     <= '0;
      ill_q   <= '0;
      drv_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      chn_trn <= trn_nxt;
      ptr     <= ptr_nxt;
      cnt     <= cnt_nxt;
      ill_q   <= ill;
      // one cycle of ungranted drive is tolerated for the release drop
      if (|(ill & ill_q)) drv_err <= 1'b1;
    end
  end

  always_comb begin
    trn_td         = TD_IDLE;
    trn_trem_n     = TREM_IDLE;
    trn_tsof_n     = 1'b1;
    trn_teof_n     = 1'b1;
    trn_tsrc_rdy_n = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (chn_trn[i]) begin
        trn_td         = ch_trn_td[64*i +: 64];
        trn_trem_n     = ch_trn_trem_n[8*i +: 8];
        trn_tsof_n     = ch_trn_tsof_n[i];
        trn_teof_n     = ch_trn_teof_n[i];
        trn_tsrc_rdy_n = ch_trn_tsrc_rdy_n[i];
      end
    end
  end

endmodule

// File: tb/tb_ep_arb.sv
// Self-checking bench for ep_arb: directed scenarios then random traffic,
// every cycle compared against a behavioural owner/gap model.
module tb_ep_arb;

  localparam int NCH = 2;
  localparam int TMO = 16;
  localparam int IW  = $clog2(NCH);

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    chn_reqep, chn_drvn, chn_trn;
  logic [64*NCH-1:0] ch_trn_td;
  logic [8*NCH-1:0]  ch_trn_trem_n;
  logic [NCH-1:0]    ch_trn_tsof_n, ch_trn_teof_n, ch_trn_tsrc_rdy_n;
  logic [63:0]       trn_td;
  logic [7:0]        trn_trem_n;
  logic              trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n;
  logic [IW-1:0]     gnt_idx;
  logic              arb_busy, drv_err;

  ep_arb #(.NCH(NCH), .GNT_TMO(TMO)) dut (
    .clk(clk), .rst(rst), .chn_reqep(chn_reqep), .chn_drvn(chn_drvn),
    .chn_trn(chn_trn), .ch_trn_td(ch_trn_td), .ch_trn_trem_n(ch_trn_trem_n),
    .ch_trn_tsof_n(ch_trn_tsof_n), .ch_trn_teof_n(ch_trn_teof_n),
    .ch_trn_tsrc_rdy_n(ch_trn_tsrc_rdy_n), .trn_td(trn_td),
    .trn_trem_n(trn_trem_n), .trn_tsof_n(trn_tsof_n), .trn_teof_n(trn_teof_n),
    .trn_tsrc_rdy_n(trn_tsrc_rdy_n), .gnt_idx(gnt_idx), .arb_busy(arb_busy),
    .drv_err(drv_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: who owns the bus, whether it is driving, how long it waited
  int             m_gnt, m_last, m_wait;
  bit             m_drv, m_gap, m_err;
  logic [NCH-1:0] m_ill_prev;

  // channel emulation
  bit auto_on, drive_en;
  int drive_pct, hold_lo, hold_hi;
  int drv_cnt[NCH];

  function automatic logic [NCH-1:0] grant_vec();
    return (m_gnt >= 0) ? (NCH'(1) << m_gnt) : '0;
  endfunction

  task automatic model_step();
    logic [NCH-1:0] ill;
    if (rst) begin
      m_gnt = -1; m_last = NCH - 1; m_wait = 0;
      m_drv = 0;  m_gap = 0;        m_err = 0; m_ill_prev = '0;
      return;
    end
    ill = chn_drvn & ~grant_vec();
    if ((ill & m_ill_prev) != '0) m_err = 1;
    m_ill_prev = ill;
    if (m_gap) begin
      m_gap = 0;
    end else if (m_gnt < 0) begin
      for (int i = 1; i <= NCH; i++) begin
        if (m_gnt < 0 && chn_reqep[(m_last + i) % NCH]) begin
          m_gnt  = (m_last + i) % NCH;
          m_last = m_gnt;
          m_wait = 0;
          m_drv  = 0;
        end
      end
    end else if (m_drv) begin
      if (!chn_drvn[m_gnt]) begin m_gnt = -1; m_gap = 1; end
    end else if (chn_drvn[m_gnt]) begin
      m_drv = 1;
    end else if (!chn_reqep[m_gnt] || m_wait == TMO - 1) begin
      m_gnt = -1; m_gap = 1;
    end else begin
      m_wait++;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    bit          g;
    logic [63:0] etd;
    logic [7:0]  erem;
    logic        esof, eeof, erdy;
    g    = (m_gnt >= 0);
    etd  = g ? ch_trn_td[64*m_gnt +: 64] : 64'h0;
    erem = g ? ch_trn_trem_n[8*m_gnt +: 8] : 8'hFF;
    esof = g ? ch_trn_tsof_n[m_gnt] : 1'b1;
    eeof = g ? ch_trn_teof_n[m_gnt] : 1'b1;
    erdy = g ? ch_trn_tsrc_rdy_n[m_gnt] : 1'b1;
    chk("chn_trn", 64'(chn_trn), 64'(grant_vec()));
    chk("gnt_idx", 64'(gnt_idx), 64'(m_last));
    chk("arb_busy", 64'(arb_busy), 64'(g));
    chk("drv_err", 64'(drv_err), 64'(m_err));
    chk("trn_td", trn_td, etd);
    chk("trn_trem_n", 64'(trn_trem_n), 64'(erem));
    chk("trn_tsof_n", 64'(trn_tsof_n), 64'(esof));
    chk("trn_teof_n", 64'(trn_teof_n), 64'(eeof));
    chk("trn_tsrc_rdy_n", 64'(trn_tsrc_rdy_n), 64'(erdy));
  endtask

  task automatic auto_chan();
    if (rst) begin
      chn_drvn = '0;
      for (int i = 0; i < NCH; i++) drv_cnt[i] = 0;
    end else if (auto_on) begin
      for (int i = 0; i < NCH; i++) begin
        if (chn_drvn[i]) begin
          drv_cnt[i]--;
          if (drv_cnt[i] <= 0) chn_drvn[i] = 1'b0;
        end else if (m_gnt == i && drive_en && $urandom_range(0, 99) < drive_pct) begin
          chn_drvn[i] = 1'b1;
          drv_cnt[i]  = $urandom_range(hold_lo, hold_hi);
        end
      end
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < NCH; i++) begin
      ch_trn_td[64*i +: 64]   = {$urandom, $urandom};
      ch_trn_trem_n[8*i +: 8] = 8'($urandom);
    end
    ch_trn_tsof_n     = NCH'($urandom);
    ch_trn_teof_n     = NCH'($urandom);
    ch_trn_tsrc_rdy_n = NCH'($urandom);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      model_step();
      @(posedge clk); #1;
      check_all();
      auto_chan();
      rand_data();
    end
  endtask

  initial begin
    rst = 1'b1; chn_reqep = '0; chn_drvn = '0;
    auto_on = 1; drive_en = 1; drive_pct = 100; hold_lo = 5; hold_hi = 5;
    for (int i = 0; i < NCH; i++) drv_cnt[i] = 0;
    rand_data();
    tick(2);
    rst = 1'b0;
    tick(2);

    // single requester, drives 5 cycles
    chn_reqep = 2'b01;
    tick(8);
    chn_reqep = 2'b00;
    tick(4);

    // two requesters held, 3-cycle transfers alternate
    hold_lo = 3; hold_hi = 3;
    chn_reqep = 2'b11;
    tick(30);
    chn_reqep = 2'b00;
    tick(8);

    // withdrawal before drive, pending ch0 picked up after the gap
    drive_en = 0;
    chn_reqep = 2'b10;
    tick(1);
    chn_reqep = 2'b01;
    tick(5);
    chn_reqep = 2'b00;
    tick(3);

    // timeout: ch0 granted, never drives, ch1 follows
    chn_reqep = 2'b10;
    tick(2);
    chn_reqep = 2'b00;
    tick(3);
    chn_reqep = 2'b11;
    tick(22);
    chn_reqep = 2'b00;
    tick(4);

    // illegal drive without grant
    auto_on = 0;
    chn_drvn = 2'b10;
    tick(2);
    chn_drvn = 2'b00;
    tick(3);
    auto_on = 1;

    // reset while ch1 is in BUSY
    drive_en = 1; hold_lo = 20; hold_hi = 20;
    chn_reqep = 2'b10;
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    hold_lo = 2; hold_hi = 2;
    chn_reqep = 2'b11;
    tick(10);
    chn_reqep = 2'b00;
    tick(6);

    // random traffic
    drive_pct = 30; hold_lo = 1; hold_hi = 6;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(0, 7) == 0) chn_reqep[i] = ~chn_reqep[i];
      tick(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ep_arb.md
Name: ep_arb

Overview:
Endpoint-level arbiter that sits directly downstream of the channel blocks. It owns the shared PCIe TRN tx interface.
- Each channel raises chn_reqep when it needs the endpoint. The arbiter grants exactly one channel at a time via chn_trn, using round-robin order.
- The granted channel signals ownership with chn_drvn and holds it for the whole transfer.
- The arbiter muxes that channel's TRN tx signals onto the core TRN tx port and masks all other channels.

Parameters:
NCH, 2, number of channels arbitrated (>=2)
GNT_TMO, 16, cycles a granted channel may take to assert chn_drvn before the grant is revoked
IW, 1, width of gnt_idx, = $clog2(NCH)
CW, 5, width of the timeout counter, = $clog2(GNT_TMO+1)

Ports:
clk  in  1  PCIe user clock
rst  in  1  synchronous active-high reset
chn_reqep  in  NCH  per-channel endpoint request
chn_drvn  in  NCH  per-channel "driving TRN tx" indication
chn_trn  out  NCH  per-channel grant, one-hot or zero, registered
ch_trn_td  in  64*NCH  channel i data at bits [64i+63:64i]
ch_trn_trem_n  in  8*NCH  per-channel rem, active low
ch_trn_tsof_n  in  NCH  per-channel sof, active low
ch_trn_teof_n  in  NCH  per-channel eof, active low
ch_trn_tsrc_rdy_n  in  NCH  per-channel src_rdy, active low
trn_td  out  64  to core
trn_trem_n  out  8  to core
trn_tsof_n  out  1  to core
trn_teof_n  out  1  to core
trn_tsrc_rdy_n  out  1  to core
gnt_idx  out  IW  index of current or last grantee
arb_busy  out  1  high in GRANT or BUSY
drv_err  out  1  sticky: a channel drove the bus without a grant

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - chn_trn=0, gnt_idx=NCH-1, arb_busy=0, drv_err=0.
  - Round-robin pointer = NCH-1, so channel 0 wins first.
  - Timeout counter = 0, state = IDLE.
- Reset mid-transfer: the grant drops in the cycle after rst is sampled, and the mux goes to idle values.
- IDLE state:
  - If any chn_reqep bit is set, pick the first requester searching from ptr+1 mod NCH upward, wrapping.
  - Register chn_trn[k]=1, gnt_idx=k, ptr=k; clear the counter; go to GRANT.
  - Latency: request sampled at cycle t gives chn_trn at t+1.
  - No requests: stay in IDLE.
- GRANT state (chn_trn[k] held):
  - chn_drvn[k]=1 -> go to BUSY.
  - Otherwise, chn_reqep[k]=0 (channel withdrew) -> chn_trn=0, go to GAP.
  - Otherwise, counter==GNT_TMO-1 -> chn_trn=0, go to GAP (timeout).
  - Otherwise increment the counter.
  - If drvn and a withdrawn request occur together, drvn wins.
- BUSY state:
  - chn_trn[k] stays held while chn_drvn[k]=1. chn_reqep is ignored in this state.
  - When chn_drvn[k] falls: chn_trn=0, go to GAP. No timeout applies in BUSY.
- GAP state: one dead cycle for bus turnaround, then IDLE. No grant is issued in GAP.
- Back-to-back grants: a channel released with another requester pending gets a new grant 2 cycles after release (GAP, then IDLE decision).
- Fairness: the pointer advances only on grant.
  - All channels requesting continuously are served 0,1,...,NCH-1,0,...
- TRN tx mux (combinational):
  - Selected by the chn_trn register. Masked to idle values when chn_trn==0: td=0, trem_n=8'hFF, sof_n/eof_n/src_rdy_n=1.
  - The granted channel may drive in the same cycle it raises chn_drvn.
  - trn_tdst_rdy_n and trn_tbuf_av are not routed through this block; they fan out to channels directly.
- drv_err: set when any chn_drvn[j]=1 with chn_trn[j]=0 for two consecutive cycles. The two-cycle window allows the one-cycle drop after release. Cleared only by rst.
- Illegal driving is not routed to the core: it is masked by the mux.

Decomposition:
- Shared package: state encoding (IDLE, GRANT, BUSY, GAP) and the TRN idle constants (TREM_IDLE=8'hFF, TD_IDLE=0).
- One natural sub-module, rr_pick: combinational round-robin priority encoder.
  - Inputs: req[NCH], ptr[IW].
  - Outputs: valid, idx[IW].
  - Reused by the channel-local arbiter.

Test Plan:
- Single requester: reqep[0]=1 at t0 -> chn_trn=01 at t0+1; drvn[0] high 5 cycles then low -> chn_trn=00 the cycle after drvn falls; trn_td equals ch_trn_td[63:0] only while granted.
- Two requesters: reqep=11 held, each drives 3 cycles -> grant order 0,1,0,1, with a 2-cycle gap between the end of one drvn and the next grant.
- Withdrawal: grant ch1, deassert reqep[1] before drvn -> chn_trn=00 next cycle, state GAP, then pending ch0 granted.
- Timeout: grant ch0 with drvn never asserted, GNT_TMO=16 -> grant dropped after 16 GRANT cycles; the pointer has advanced to 0, so ch1 (if requesting) is granted next.
- Illegal drive: drvn[1]=1 for 2 cycles with chn_trn=00 -> drv_err=1 and stays 1; trn_tsrc_rdy_n stays 1.
- Reset mid-BUSY: rst pulse while ch1 in BUSY -> chn_trn=00, outputs idle, gnt_idx=NCH-1; the next simultaneous request is granted to ch0.
